// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between IF/MEM stages, the arbiter and the unified memory.
// slave = arbiter view; master = datapath + memory view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              if_err;
   logic              stall_if;

   logic                d_req;
   logic                d_we;
   logic [ADDR_W-1:0]   d_addr;
   logic [DATA_W-1:0]   d_wdata;
   logic [DATA_W/8-1:0] d_wstrb;
   logic [DATA_W-1:0]   d_rdata;
   logic                d_ack;
   logic                d_err;
   logic                stall_mem;

   logic                mem_req;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W/8-1:0] mem_wstrb;
   logic [DATA_W-1:0]   mem_rdata;
   logic                mem_ack;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ack,
      output if_rdata, if_ack, if_err, stall_if, d_rdata, d_ack, d_err, stall_mem,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ack,
      input  if_rdata, if_ack, if_err, stall_if, d_rdata, d_ack, d_err, stall_mem,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store; one registered grant at a time,
// min 3 cycles per access (grant, >=1 busy, gap); waiting requester sees its stall output high.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input logic clock,
   input logic reset,
   mem_port_arbiter_if.slave bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      D_BUSY  = 2'd2,
      GAP     = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [SW-1:0]   starve_cnt;
   logic [TW-1:0]   timeout_cnt;
   logic            grant_if, grant_d, timed_out, busy;

   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_d   = 1'b0;
      timed_out = 1'b0;
      busy      = (state == IF_BUSY) || (state == D_BUSY);
      case (state)
         IDLE: begin
            if (bus.if_req && (!bus.d_req || starve_cnt == SW'(STARVE_LIMIT))) begin
               grant_if  = 1'b1;
               state_nxt = IF_BUSY;
            end else if (bus.d_req) begin
               grant_d   = 1'b1;
               state_nxt = D_BUSY;
            end
         end
         IF_BUSY, D_BUSY: begin
            // An ack arriving on the timeout cycle still completes normally.
            if (bus.mem_ack) begin
               state_nxt = GAP;
            end else if (timeout_cnt == TW'(TIMEOUT - 2)) begin
               timed_out = 1'b1;
               state_nxt = GAP;
            end
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A flushed requester still lets the memory finish, but never sees the ack.
   assign bus.if_ack    = (state == IF_BUSY) && bus.mem_ack && bus.if_req;
   assign bus.d_ack     = (state == D_BUSY)  && bus.mem_ack && bus.d_req;
   assign bus.if_err    = (state == IF_BUSY) && timed_out;
   assign bus.d_err     = (state == D_BUSY)  && timed_out;
   assign bus.if_rdata  = bus.if_ack ? bus.mem_rdata : '0;
   assign bus.d_rdata   = bus.d_ack  ? bus.mem_rdata : '0;
   assign bus.stall_if  = bus.if_req && !bus.if_ack;
   assign bus.stall_mem = bus.d_req  && !bus.d_ack;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wstrb <= '0;
         starve_cnt    <= '0;
         timeout_cnt   <= '0;
      end else begin
         state <= state_nxt;

         if (grant_if) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
         end else if (grant_d) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            bus.mem_wstrb <= bus.d_we ? bus.d_wstrb : '0;
         end else if (busy && state_nxt == GAP) begin
            bus.mem_req   <= 1'b0;
         end

         if (grant_if || grant_d) begin
            timeout_cnt <= '0;
         end else if (busy && !bus.mem_ack) begin
            timeout_cnt <= timeout_cnt + 1'b1;
         end

         if (state == IDLE) begin
            if (!bus.if_req || grant_if) begin
               starve_cnt <= '0;
            end else if (grant_d && starve_cnt != SW'(STARVE_LIMIT)) begin
               starve_cnt <= starve_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of mem_port_arbiter: grant order, starvation bound, timeout, flush, async reset.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_mem_port_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clock = ~clock;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(8)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bus.mem_req) begin
            ok = 1'b1;
            break;
         end
         step();
         #1;
      end
   endtask

   initial begin
      bit ok;
      bus.if_req = 1'b1; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
      bus.mem_rdata = '0; bus.mem_ack = 1'b0;

      // reset state
      #2;
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wstrb", bus.mem_wstrb, 0);
      check("rst_stall_if", bus.stall_if, 1);
      check("rst_if_ack", bus.if_ack, 0);
      bus.if_req = 1'b0;
      step(); step();
      reset = 1'b0;
      step();

      // fetch only
      bus.if_req = 1'b1; bus.if_addr = 32'h10; #1;
      check("f_idle_stall", bus.stall_if, 1);
      check("f_idle_req", bus.mem_req, 0);
      step(); #1;
      check("f_busy_req", bus.mem_req, 1);
      check("f_busy_addr", bus.mem_addr, 32'h10);
      check("f_busy_we", bus.mem_we, 0);
      check("f_busy_stall", bus.stall_if, 1);
      bus.mem_rdata = 32'h1234_5678; bus.mem_ack = 1'b1; #1;
      check("f_ack", bus.if_ack, 1);
      check("f_rdata", bus.if_rdata, 32'h1234_5678);
      check("f_ack_stall", bus.stall_if, 0);
      check("f_d_ack", bus.d_ack, 0);
      step(); bus.mem_ack = 1'b0; bus.if_req = 1'b0; #1;
      check("f_gap_req", bus.mem_req, 0);
      check("f_gap_rdata", bus.if_rdata, 0);
      step();

      // simultaneous fetch and store: data first
      bus.if_req = 1'b1; bus.if_addr = 32'h14;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100;
      bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'hF; #1;
      check("s_idle_stall_if", bus.stall_if, 1);
      check("s_idle_stall_mem", bus.stall_mem, 1);
      step(); #1;
      check("s_busy_we", bus.mem_we, 1);
      check("s_busy_addr", bus.mem_addr, 32'h100);
      check("s_busy_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      check("s_busy_wstrb", bus.mem_wstrb, 4'hF);
      bus.mem_ack = 1'b1; bus.mem_rdata = '0; #1;
      check("s_d_ack", bus.d_ack, 1);
      check("s_if_ack", bus.if_ack, 0);
      check("s_stall_mem", bus.stall_mem, 0);
      check("s_stall_if", bus.stall_if, 1);
      step(); bus.mem_ack = 1'b0; bus.d_req = 1'b0; #1;
      check("s_gap_req", bus.mem_req, 0);
      check("s_gap_stall_if", bus.stall_if, 1);
      step(); #1;
      check("s_idle2_req", bus.mem_req, 0);
      check("s_idle2_stall_if", bus.stall_if, 1);
      step(); #1;
      check("s_f_req", bus.mem_req, 1);
      check("s_f_addr", bus.mem_addr, 32'h14);
      check("s_f_we", bus.mem_we, 0);
      check("s_f_wstrb", bus.mem_wstrb, 0);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D; #1;
      check("s_f_rdata", bus.if_rdata, 32'hCAFE_F00D);
      step(); bus.mem_ack = 1'b0; bus.if_req = 1'b0;
      step();

      // starvation bound: four stores, then the fetch
      bus.if_req = 1'b1; bus.if_addr = 32'h20;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300; bus.d_wstrb = 4'h3; #1;
      for (int g = 0; g < 5; g++) begin
         wait_grant(ok);
         check("starve_grant_seen", ok, 1);
         check("starve_grant_is_store", bus.mem_we, (g < 4) ? 1 : 0);
         bus.mem_ack = 1'b1; #1;
         step(); bus.mem_ack = 1'b0; #1;
      end
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      step();

      // timeout without ack
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
      step();
      for (int c = 1; c <= 7; c++) begin
         #1;
         check("to_d_err", bus.d_err, (c == 7) ? 1 : 0);
         if (c == 7) begin
            check("to_no_ack", bus.d_ack, 0);
            check("to_req_last", bus.mem_req, 1);
         end else begin
            step();
         end
      end
      step(); #1;
      check("to_gap_req", bus.mem_req, 0);
      check("to_gap_err", bus.d_err, 0);
      bus.d_req = 1'b0;
      step();

      // ack on the timeout cycle wins
      bus.d_req = 1'b1;
      step();
      for (int c = 1; c <= 6; c++) begin
         #1;
         check("tw_no_err", bus.d_err, 0);
         step();
      end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA5A5_0001; #1;
      check("tw_ack", bus.d_ack, 1);
      check("tw_err", bus.d_err, 0);
      check("tw_rdata", bus.d_rdata, 32'hA5A5_0001);
      step(); bus.mem_ack = 1'b0; bus.d_req = 1'b0; #1;
      check("tw_gap_req", bus.mem_req, 0);
      step();

      // fetch flushed mid-busy
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      step(); #1;
      check("fl_busy_req", bus.mem_req, 1);
      bus.if_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55; #1;
      check("fl_if_ack", bus.if_ack, 0);
      check("fl_if_rdata", bus.if_rdata, 0);
      step(); bus.mem_ack = 1'b0; #1;
      check("fl_gap_req", bus.mem_req, 0);
      step();
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44; #1;
      check("fl_idle_req", bus.mem_req, 0);
      step(); #1;
      check("fl_next_req", bus.mem_req, 1);
      check("fl_next_addr", bus.mem_addr, 32'h44);

      // async reset in the middle of a data access
      #1 reset = 1'b1;
      #1;
      check("ar_mem_req", bus.mem_req, 0);
      check("ar_mem_addr", bus.mem_addr, 0);
      check("ar_stall_mem", bus.stall_mem, 1);
      step(); reset = 1'b0; bus.d_req = 1'b0;
      step(); #1;
      check("ar_idle_req", bus.mem_req, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
